id_ex_stage: RTL and testbench

ID/EX pipeline stage for the 16-bit, 16-register pipelined core. It registers decoded operands and control from ID into the EX-side fields (EX_opcode, EX_rs, EX_rt, EX_rd, operand data, RegWrite/MemWrite) that feed the EX forwarding logic. It also owns load-use hazard detection, bubble insertion, flush squashing and the sticky halt state.

---
 rtl/id_ex_stage.sv | 181 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, bubble/flush handling and sticky halt.
// Optional PERF_CNT_EN macro enables saturating stall/bubble performance counters.
module id_ex_stage #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ID_valid,
  input  logic [3:0]        ID_opcode,
  input  logic [REG_AW-1:0] ID_rs,
  input  logic [REG_AW-1:0] ID_rt,
  input  logic [REG_AW-1:0] ID_rd,
  input  logic [DATA_W-1:0] ID_rs_data,
  input  logic [DATA_W-1:0] ID_rt_data,
  input  logic [DATA_W-1:0] ID_imm,
  input  logic [DATA_W-1:0] ID_pc_plus2,
  input  logic              ID_RegWrite,
  input  logic              ID_MemWrite,
  input  logic              ID_MemRead,
  input  logic              flush,
  input  logic              mem_stall,
  output logic              EX_valid,
  output logic [3:0]        EX_opcode,
  output logic [REG_AW-1:0] EX_rs,
  output logic [REG_AW-1:0] EX_rt,
  output logic [REG_AW-1:0] EX_rd,
  output logic [DATA_W-1:0] EX_rs_data,
  output logic [DATA_W-1:0] EX_rt_data,
  output logic [DATA_W-1:0] EX_imm,
  output logic [DATA_W-1:0] EX_pc_plus2,
  output logic              EX_RegWrite,
  output logic              EX_MemWrite,
  output logic              EX_MemRead,
  output logic              lu_stall,
  output logic              halted,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       bubble_cnt
);

  localparam int unsigned CNT_W = 16;

  localparam logic [1:0] RUN      = 2'b00;
  localparam logic [1:0] LU_STALL = 2'b01;
  localparam logic [1:0] HALTED   = 2'b10;

  localparam logic [3:0] OP_ADD    = 4'b0000;
  localparam logic [3:0] OP_SUB    = 4'b0001;
  localparam logic [3:0] OP_XOR    = 4'b0010;
  localparam logic [3:0] OP_RED    = 4'b0011;
  localparam logic [3:0] OP_SLL    = 4'b0100;
  localparam logic [3:0] OP_SRA    = 4'b0101;
  localparam logic [3:0] OP_ROR    = 4'b0110;
  localparam logic [3:0] OP_PADDSB = 4'b0111;
  localparam logic [3:0] OP_LW     = 4'b1000;
  localparam logic [3:0] OP_SW     = 4'b1001;
  localparam logic [3:0] OP_LLB    = 4'b1010;
  localparam logic [3:0] OP_LHB    = 4'b1011;
  localparam logic [3:0] OP_BR     = 4'b1101;
  localparam logic [3:0] OP_HLT    = 4'b1111;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       uses_rs;
  logic       uses_rt;
  logic       uses_rd;
  logic       src_match;
  logic       hazard;
  logic       halt_req;
  logic       hold;
  logic       load_bubble;

  // Which register fields the ID instruction actually reads.
  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    uses_rd = 1'b0;
    case (ID_opcode)
      OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_SW, OP_BR: uses_rs = 1'b1;
      OP_LLB, OP_LHB:                              uses_rd = 1'b1;
      default: ;
    endcase
  end

  assign src_match = (uses_rs && (ID_rs == EX_rd)) ||
                     (uses_rt && (ID_rt == EX_rd)) ||
                     (uses_rd && (ID_rd == EX_rd));

  assign hazard = (state_q == RUN) && ID_valid && EX_valid && EX_MemRead &&
                  (EX_rd != REG_AW'(0)) && src_match;

  assign lu_stall = hazard && !flush && !mem_stall;
  assign halt_req = (state_q == RUN) && EX_valid && (EX_opcode == OP_HLT);

  // Next state and EX-register load selection, in edge priority order.
  always_comb begin
    state_d     = state_q;
    hold        = 1'b0;
    load_bubble = 1'b0;
    if (state_q == HALTED) begin
      load_bubble = 1'b1;
    end else if (mem_stall) begin
      hold = 1'b1;
    end else if (halt_req) begin
      state_d     = HALTED;
      load_bubble = 1'b1;
    end else if (flush) begin
      state_d     = RUN;
      load_bubble = 1'b1;
    end else if (lu_stall) begin
      state_d     = LU_STALL;
      load_bubble = 1'b1;
    end else begin
      state_d     = RUN;
      load_bubble = !ID_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      halted  <= 1'b0;
    end else begin
      state_q <= state_d;
      halted  <= (state_d == HALTED);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || (!hold && load_bubble)) begin
      EX_valid    <= 1'b0;
      EX_opcode   <= 4'd0;
      EX_rs       <= '0;
      EX_rt       <= '0;
      EX_rd       <= '0;
      EX_rs_data  <= '0;
      EX_rt_data  <= '0;
      EX_imm      <= '0;
      EX_pc_plus2 <= '0;
      EX_RegWrite <= 1'b0;
      EX_MemWrite <= 1'b0;
      EX_MemRead  <= 1'b0;
    end else if (!hold) begin
      EX_valid    <= 1'b1;
      EX_opcode   <= ID_opcode;
      EX_rs       <= ID_rs;
      EX_rt       <= ID_rt;
      EX_rd       <= ID_rd;
      EX_rs_data  <= ID_rs_data;
      EX_rt_data  <= ID_rt_data;
      EX_imm      <= ID_imm;
      EX_pc_plus2 <= ID_pc_plus2;
      EX_RegWrite <= ID_RegWrite;
      EX_MemWrite <= ID_MemWrite;
      EX_MemRead  <= ID_MemRead;
    end
  end

`ifdef PERF_CNT_EN
  // Saturating counters, frozen while memory is busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else if (!mem_stall) begin
      if (lu_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (load_bubble && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end
`else
  assign stall_cnt  = CNT_W'(0);
  assign bubble_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage: load-use hazards, flush, mem_stall, halt and reset.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_valid;
  logic [3:0]  ID_opcode;
  logic [3:0]  ID_rs, ID_rt, ID_rd;
  logic [15:0] ID_rs_data, ID_rt_data, ID_imm, ID_pc_plus2;
  logic        ID_RegWrite, ID_MemWrite, ID_MemRead;
  logic        flush, mem_stall;
  logic        EX_valid;
  logic [3:0]  EX_opcode;
  logic [3:0]  EX_rs, EX_rt, EX_rd;
  logic [15:0] EX_rs_data, EX_rt_data, EX_imm, EX_pc_plus2;
  logic        EX_RegWrite, EX_MemWrite, EX_MemRead;
  logic        lu_stall, halted;
  logic [15:0] stall_cnt, bubble_cnt;

  int tests = 0;
  int fails = 0;

`ifdef PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  id_ex_stage #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_valid(ID_valid), .ID_opcode(ID_opcode),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_rs_data(ID_rs_data), .ID_rt_data(ID_rt_data),
    .ID_imm(ID_imm), .ID_pc_plus2(ID_pc_plus2),
    .ID_RegWrite(ID_RegWrite), .ID_MemWrite(ID_MemWrite), .ID_MemRead(ID_MemRead),
    .flush(flush), .mem_stall(mem_stall),
    .EX_valid(EX_valid), .EX_opcode(EX_opcode),
    .EX_rs(EX_rs), .EX_rt(EX_rt), .EX_rd(EX_rd),
    .EX_rs_data(EX_rs_data), .EX_rt_data(EX_rt_data),
    .EX_imm(EX_imm), .EX_pc_plus2(EX_pc_plus2),
    .EX_RegWrite(EX_RegWrite), .EX_MemWrite(EX_MemWrite), .EX_MemRead(EX_MemRead),
    .lu_stall(lu_stall), .halted(halted),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [3:0] op, input logic [3:0] rs, input logic [3:0] rt,
                        input logic [3:0] rd, input logic [15:0] rsd, input logic [15:0] rtd,
                        input logic [15:0] imm);
    ID_valid    = 1'b1;
    ID_opcode   = op;
    ID_rs       = rs;
    ID_rt       = rt;
    ID_rd       = rd;
    ID_rs_data  = rsd;
    ID_rt_data  = rtd;
    ID_imm      = imm;
    ID_pc_plus2 = ID_pc_plus2 + 16'd2;
    ID_RegWrite = (op <= 4'd8) || (op == 4'd10) || (op == 4'd11);
    ID_MemRead  = (op == 4'd8);
    ID_MemWrite = (op == 4'd9);
    #1;
  endtask

  task automatic set_idle();
    ID_valid = 1'b0; ID_opcode = 4'd0; ID_rs = 4'd0; ID_rt = 4'd0; ID_rd = 4'd0;
    ID_rs_data = 16'd0; ID_rt_data = 16'd0; ID_imm = 16'd0; ID_pc_plus2 = 16'd0;
    ID_RegWrite = 1'b0; ID_MemWrite = 1'b0; ID_MemRead = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    set_idle();
    // Reset state
    tick();
    chk("rst_valid", 16'(EX_valid), 16'd0);
    chk("rst_opcode", 16'(EX_opcode), 16'd0);
    chk("rst_halted", 16'(halted), 16'd0);
    chk("rst_lu_stall", 16'(lu_stall), 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_bubble_cnt", bubble_cnt, 16'd0);

    // Load-use hazard on rs
    rst_n = 1'b1;
    set_id(4'd8, 4'd1, 4'd0, 4'd3, 16'h0100, 16'h0000, 16'h0004);
    tick();
    chk("lw_opcode", 16'(EX_opcode), 16'h8);
    chk("lw_memread", 16'(EX_MemRead), 16'd1);
    chk("lw_regwrite", 16'(EX_RegWrite), 16'd1);
    chk("lw_rd", 16'(EX_rd), 16'd3);
    chk("lw_pc", EX_pc_plus2, 16'd2);
    set_id(4'd0, 4'd3, 4'd4, 4'd5, 16'h1111, 16'h2222, 16'h0000);
    chk("rs_haz_lu", 16'(lu_stall), 16'd1);
    tick();
    chk("bubble_valid", 16'(EX_valid), 16'd0);
    chk("bubble_regwrite", 16'(EX_RegWrite), 16'd0);
    chk("bubble_rs_data", EX_rs_data, 16'd0);
    chk("bubble_lu_clear", 16'(lu_stall), 16'd0);
    tick();
    chk("dep_valid", 16'(EX_valid), 16'd1);
    chk("dep_opcode", 16'(EX_opcode), 16'h0);
    chk("dep_rs", 16'(EX_rs), 16'd3);
    chk("dep_rt", 16'(EX_rt), 16'd4);
    chk("dep_rd", 16'(EX_rd), 16'd5);
    chk("dep_rs_data", EX_rs_data, 16'h1111);
    chk("dep_rt_data", EX_rt_data, 16'h2222);
    chk("stall_cnt_1", stall_cnt, PERF ? 16'd1 : 16'd0);
    chk("bubble_cnt_1", bubble_cnt, PERF ? 16'd1 : 16'd0);

    // SW store data is not a hazard source
    set_id(4'd8, 4'd1, 4'd0, 4'd3, 16'h0100, 16'h0000, 16'h0004);
    tick();
    set_id(4'd9, 4'd2, 4'd3, 4'd0, 16'h0200, 16'h3333, 16'h0002);
    chk("sw_no_haz", 16'(lu_stall), 16'd0);
    tick();
    chk("sw_opcode", 16'(EX_opcode), 16'h9);
    chk("sw_rt", 16'(EX_rt), 16'd3);
    chk("sw_memwrite", 16'(EX_MemWrite), 16'd1);
    chk("sw_imm", EX_imm, 16'h0002);

    // LHB reads rd; flush overrides the hazard
    set_id(4'd8, 4'd1, 4'd0, 4'd3, 16'h0100, 16'h0000, 16'h0004);
    tick();
    set_id(4'd11, 4'd0, 4'd0, 4'd3, 16'h0000, 16'h0000, 16'h00AB);
    chk("lhb_haz", 16'(lu_stall), 16'd1);
    flush = 1'b1;
    #1;
    chk("flush_lu", 16'(lu_stall), 16'd0);
    tick();
    flush = 1'b0;
    chk("flush_valid", 16'(EX_valid), 16'd0);
    chk("flush_opcode", 16'(EX_opcode), 16'd0);

    // Destination R0 never hazards
    set_id(4'd8, 4'd1, 4'd0, 4'd0, 16'h0100, 16'h0000, 16'h0004);
    tick();
    set_id(4'd0, 4'd0, 4'd0, 4'd6, 16'h0000, 16'h0000, 16'h0000);
    chk("r0_no_haz", 16'(lu_stall), 16'd0);
    tick();
    chk("r0_valid", 16'(EX_valid), 16'd1);
    chk("r0_rd", 16'(EX_rd), 16'd6);

    // mem_stall around a load-use stall, counters restarted by reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_id(4'd8, 4'd1, 4'd0, 4'd3, 16'h0100, 16'h0000, 16'h0004);
    tick();
    set_id(4'd0, 4'd3, 4'd4, 4'd5, 16'h1111, 16'h2222, 16'h0000);
    mem_stall = 1'b1;
    #1;
    chk("ms_masks_lu", 16'(lu_stall), 16'd0);
    tick();
    chk("ms_hold_lw", 16'(EX_opcode), 16'h8);
    mem_stall = 1'b0;
    #1;
    chk("ms_lu_again", 16'(lu_stall), 16'd1);
    tick();
    chk("ms_bubble", 16'(EX_valid), 16'd0);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ms_hold_valid", 16'(EX_valid), 16'd0);
      chk("ms_hold_lu", 16'(lu_stall), 16'd0);
    end
    mem_stall = 1'b0;
    #1;
    chk("ms_no_rehaz", 16'(lu_stall), 16'd0);
    tick();
    chk("ms_dep_valid", 16'(EX_valid), 16'd1);
    chk("ms_dep_rs", 16'(EX_rs), 16'd3);
    chk("ms_stall_cnt", stall_cnt, PERF ? 16'd1 : 16'd0);
    chk("ms_bubble_cnt", bubble_cnt, PERF ? 16'd1 : 16'd0);

    // Halt is sticky until reset
    set_id(4'd15, 4'd0, 4'd0, 4'd0, 16'h0000, 16'h0000, 16'h0000);
    tick();
    chk("hlt_in_ex", 16'(EX_opcode), 16'hF);
    chk("hlt_not_yet", 16'(halted), 16'd0);
    set_id(4'd0, 4'd1, 4'd2, 4'd7, 16'h0005, 16'h0006, 16'h0000);
    tick();
    chk("halted_set", 16'(halted), 16'd1);
    chk("halted_bubble", 16'(EX_valid), 16'd0);
    tick();
    chk("halted_ignore", 16'(EX_valid), 16'd0);
    chk("halted_sticky", 16'(halted), 16'd1);
    mem_stall = 1'b1;
    tick();
    mem_stall = 1'b0;
    chk("halted_ms", 16'(halted), 16'd1);
    chk("halted_bubble_cnt", bubble_cnt, PERF ? 16'd3 : 16'd0);
    rst_n = 1'b0;
    tick();
    chk("rst_halted_clr", 16'(halted), 16'd0);
    chk("rst_ex_valid", 16'(EX_valid), 16'd0);
    chk("rst_ex_rd", 16'(EX_rd), 16'd0);
    chk("rst_ex_pc", EX_pc_plus2, 16'd0);
    rst_n = 1'b1;
    tick();
    chk("run_after_rst", 16'(EX_valid), 16'd1);
    chk("run_after_rst_rd", 16'(EX_rd), 16'd7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
